fft_top_control: RTL and testbench

Top-level controller and datapath for a 32-point complex FFT on 9-bit minifloat samples. It accepts all 32 samples and a twiddle table in parallel, converts them to signed fixed point, and runs an iterative radix-2 decimation-in-time FFT on one butterfly unit. It then converts the results back to minifloat and presents them in parallel with a one-cycle `fft_done` pulse. It sits between the sample/twiddle buffers and the consumer of spectral data.

---
 rtl/fft_pkg.sv | 90 +++++++++
 rtl/fft_butterfly.sv | 42 ++++
 rtl/fft_top_control.sv | 131 +++++++++++++
 tb/tb_fft_top_control.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types, constants and minifloat <-> fixed-point conversion for the
// 32-point minifloat FFT controller.
package fft_pkg;

    localparam int unsigned format_width = 9;
    localparam int unsigned exp_width    = 4;
    localparam int unsigned sig_width    = 4;
    localparam int unsigned low_expand   = 3;
    localparam int unsigned fix_width    = 21;
    localparam int unsigned n_points     = 32;
    localparam int unsigned n_stages     = 5;
    localparam int unsigned n_twiddles   = n_points / 4;
    localparam int unsigned bias         = 1 << (exp_width - 1);
    localparam int unsigned frac_bits    = sig_width + low_expand;
    localparam int unsigned dec_point    = bias + sig_width - frac_bits;
    localparam int unsigned enc_offset   = bias - frac_bits;
    localparam int unsigned exp_max      = (1 << exp_width) - 1;
    localparam int unsigned wide_width   = 2 * fix_width + 1;

    typedef logic [format_width-1:0]      mf_t;
    typedef logic signed [fix_width-1:0]  fix_t;
    typedef logic signed [wide_width-1:0] wide_t;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_ENCODE} fft_state_t;

    localparam wide_t fix_max_wide = wide_t'((1 << (fix_width - 1)) - 1);
    localparam wide_t fix_min_wide = -fix_max_wide - wide_t'(1);

    function automatic logic [n_stages-1:0] bit_reverse(input logic [n_stages-1:0] idx);
        return {<<{idx}};
    endfunction

    function automatic fix_t sat_fix(input wide_t x);
        if (x > fix_max_wide) return fix_t'(fix_max_wide);
        if (x < fix_min_wide) return fix_t'(fix_min_wide);
        return fix_t'(x);
    endfunction

    function automatic fix_t mf_to_fix(input mf_t x);
        logic [fix_width-1:0] mag;
        int unsigned          ev;
        ev  = 32'(x[format_width-2 -: exp_width]);
        mag = fix_width'({1'b1, x[sig_width-1:0]});
        if (ev >= dec_point) mag = mag << (ev - dec_point);
        else                 mag = mag >> (dec_point - ev);
        if (ev == 0) return '0;
        return x[format_width-1] ? -fix_t'(mag) : fix_t'(mag);
    endfunction

    // Rounding carry out of the fraction bumps the exponent; the
    // renormalised fraction is then all zeros.
    function automatic mf_t fix_to_mf(input fix_t v);
        logic [fix_width-1:0]   mag;
        logic [fix_width-1:0]   sh;
        logic [sig_width+1:0]   rsum;
        logic                   rnd;
        int unsigned            p;
        int unsigned            ef;
        mf_t                    r;
        mag = v[fix_width-1] ? fix_width'(-v) : fix_width'(v);
        p   = 0;
        rnd = 1'b0;
        for (int unsigned i = 0; i < fix_width; i++) begin
            sh = mag >> i;
            if (sh[0]) p = i;
        end
        if (p >= sig_width) begin
            sh   = mag >> (p - sig_width);
            rsum = {1'b0, sh[sig_width:0]};
            if (p > sig_width) begin
                sh  = mag >> (p - sig_width - 1);
                rnd = sh[0];
            end
        end else begin
            sh   = mag << (sig_width - p);
            rsum = {1'b0, sh[sig_width:0]};
        end
        rsum = rsum + (sig_width+2)'(rnd);
        ef   = p + enc_offset;
        if (rsum[sig_width+1]) begin
            ef   = ef + 1;
            rsum = rsum >> 1;
        end
        if (v == '0)          r = '0;
        else if (ef > exp_max) r = {v[fix_width-1], {(format_width-1){1'b1}}};
        else                  r = {v[fix_width-1], exp_width'(ef), rsum[sig_width-1:0]};
        return r;
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: t = b*w with per-product round-half-up,
// then saturating a+t / a-t.
module fft_butterfly
    import fft_pkg::*;
(
    input  fix_t a_re,
    input  fix_t a_im,
    input  fix_t b_re,
    input  fix_t b_im,
    input  fix_t w_re,
    input  fix_t w_im,
    output fix_t x_re,
    output fix_t x_im,
    output fix_t y_re,
    output fix_t y_im
);

    localparam int round_half = 1 << (frac_bits - 1);

    function automatic wide_t round_prod(input fix_t x, input fix_t y);
        wide_t pr;
        pr = wide_t'(x) * wide_t'(y);
        return (pr + wide_t'(round_half)) >>> frac_bits;
    endfunction

    wide_t rr, ii, ri, ir;
    fix_t  t_re, t_im;

    always_comb begin
        rr   = round_prod(b_re, w_re);
        ii   = round_prod(b_im, w_im);
        ri   = round_prod(b_re, w_im);
        ir   = round_prod(b_im, w_re);
        t_re = sat_fix(rr - ii);
        t_im = sat_fix(ri + ir);
        x_re = sat_fix(wide_t'(a_re) + wide_t'(t_re));
        x_im = sat_fix(wide_t'(a_im) + wide_t'(t_im));
        y_re = sat_fix(wide_t'(a_re) - wide_t'(t_re));
        y_im = sat_fix(wide_t'(a_im) - wide_t'(t_im));
    end

endmodule

// File: rtl/fft_top_control.sv
// 32-point iterative radix-2 DIT FFT on minifloat samples: load, 80 single
// butterfly cycles, encode, one-cycle fft_done pulse.
module fft_top_control
    import fft_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [10:0]                      fft_size,
    input  logic                             fft_start,
    input  logic [n_points*format_width-1:0] input_real,
    input  logic [n_points*format_width-1:0] input_imag,
    input  logic [n_points*format_width-1:0] twiddle_real,
    input  logic [n_points*format_width-1:0] twiddle_imag,
    output logic [n_points*format_width-1:0] output_real,
    output logic [n_points*format_width-1:0] output_imag,
    output logic                             fft_done
);

    fft_state_t state_q, state_d;
    logic [2:0] stage_q;
    logic [3:0] bfly_q;
    fix_t       x_re [n_points];
    fix_t       x_im [n_points];
    fix_t       tw_re [n_twiddles];
    fix_t       tw_im [n_twiddles];

    logic [4:0] half, pos, idx_a, idx_b;
    logic [3:0] tw_exp;
    logic       last_bfly;
    fix_t       w_re, w_im, bx_re, bx_im, by_re, by_im;
    logic       unused_tw;

    // Only entries 4e+2 are decoded; the rest of the table is ignored.
    assign unused_tw = ^{twiddle_real, twiddle_imag};

    // idx_a inserts a zero bit at position 'stage' into the butterfly number.
    always_comb begin
        half      = 5'd1 << stage_q;
        pos       = {1'b0, bfly_q} & (half - 5'd1);
        idx_a     = pos | (({1'b0, bfly_q} & ~(half - 5'd1)) << 1);
        idx_b     = idx_a | half;
        tw_exp    = 4'(pos << (3'd4 - stage_q));
        last_bfly = (stage_q == 3'd4) && (bfly_q == 4'hF);
        if (tw_exp[3]) begin
            w_re = tw_im[tw_exp[2:0]];
            w_im = -tw_re[tw_exp[2:0]];
        end else begin
            w_re = tw_re[tw_exp[2:0]];
            w_im = tw_im[tw_exp[2:0]];
        end
    end

    fft_butterfly u_butterfly (
        .a_re (x_re[idx_a]),
        .a_im (x_im[idx_a]),
        .b_re (x_re[idx_b]),
        .b_im (x_im[idx_b]),
        .w_re (w_re),
        .w_im (w_im),
        .x_re (bx_re),
        .x_im (bx_im),
        .y_re (by_re),
        .y_im (by_im)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fft_start && fft_size == 11'd32) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_RUN;
            ST_RUN:    if (last_bfly) state_d = ST_ENCODE;
            ST_ENCODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= '0;
            bfly_q      <= '0;
            fft_done    <= 1'b0;
            output_real <= '0;
            output_imag <= '0;
            for (int unsigned i = 0; i < n_points; i++) begin
                x_re[i] <= '0;
                x_im[i] <= '0;
            end
            for (int unsigned i = 0; i < n_twiddles; i++) begin
                tw_re[i] <= '0;
                tw_im[i] <= '0;
            end
        end else begin
            fft_done <= (state_q == ST_ENCODE);
            case (state_q)
                ST_LOAD: begin
                    stage_q <= '0;
                    bfly_q  <= '0;
                    for (int unsigned i = 0; i < n_points; i++) begin
                        x_re[bit_reverse(n_stages'(i))] <= mf_to_fix(input_real[i*format_width +: format_width]);
                        x_im[bit_reverse(n_stages'(i))] <= mf_to_fix(input_imag[i*format_width +: format_width]);
                    end
                    for (int unsigned e = 0; e < n_twiddles; e++) begin
                        tw_re[e] <= mf_to_fix(twiddle_real[(4*e+2)*format_width +: format_width]);
                        tw_im[e] <= mf_to_fix(twiddle_imag[(4*e+2)*format_width +: format_width]);
                    end
                end
                ST_RUN: begin
                    x_re[idx_a] <= bx_re;
                    x_im[idx_a] <= bx_im;
                    x_re[idx_b] <= by_re;
                    x_im[idx_b] <= by_im;
                    bfly_q      <= bfly_q + 4'd1;
                    if (bfly_q == 4'hF) stage_q <= stage_q + 3'd1;
                end
                ST_ENCODE: begin
                    for (int unsigned k = 0; k < n_points; k++) begin
                        output_real[k*format_width +: format_width] <= fix_to_mf(x_re[k]);
                        output_imag[k*format_width +: format_width] <= fix_to_mf(x_im[k]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_top_control.sv
// Self-checking bench for fft_top_control: random and directed spectra
// against a behavioural integer FFT model, plus control/reset scenarios.
module tb_fft_top_control;

    localparam int N = 32;
    localparam int W = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic [10:0]    fft_size;
    logic           fft_start;
    logic [N*W-1:0] in_re, in_im, tw_re, tw_im;
    logic [N*W-1:0] out_re, out_im;
    logic           fft_done;
    logic [N*W-1:0] exp_re, exp_im;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_top_control dut (
        .clk          (clk),
        .rst          (rst),
        .fft_size     (fft_size),
        .fft_start    (fft_start),
        .input_real   (in_re),
        .input_imag   (in_im),
        .twiddle_real (tw_re),
        .twiddle_imag (tw_im),
        .output_real  (out_re),
        .output_imag  (out_im),
        .fft_done     (fft_done)
    );

    function automatic longint m_dec(input logic [8:0] x);
        int     e;
        longint m;
        e = int'(x[7:4]);
        m = 16 + longint'(x[3:0]);
        if (e == 0) return 0;
        if (e >= 5) m = m << (e - 5);
        else        m = m >> (5 - e);
        return x[8] ? -m : m;
    endfunction

    function automatic logic [8:0] m_enc(input longint v);
        longint mag, scale, q, rem;
        int     p, ef;
        logic   s;
        if (v == 0) return 9'd0;
        s   = (v < 0);
        mag = s ? -v : v;
        p   = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p >= 4) begin
            scale = longint'(1) << (p - 4);
            q     = mag / scale;
            rem   = mag % scale;
            if (p >= 5 && 2 * rem >= scale) q++;
        end else begin
            q = mag << (4 - p);
        end
        ef = p + 1;
        if (q == 32) begin
            q = 16;
            ef++;
        end
        if (ef > 15) return {s, 8'hFF};
        return {s, ef[3:0], q[3:0]};
    endfunction

    function automatic longint clampf(input longint v);
        if (v > 1048575)  return 1048575;
        if (v < -1048576) return -1048576;
        return v;
    endfunction

    function automatic longint rnd7(input longint p);
        return (p + 64) >>> 7;
    endfunction

    function automatic int bitrev5(input int n);
        int r = 0;
        for (int i = 0; i < 5; i++) if (n & (1 << i)) r |= 1 << (4 - i);
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < 9; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [N*W-1:0] rand_samples();
        logic [N*W-1:0] v;
        logic [8:0]     s;
        for (int i = 0; i < N; i++) begin
            s = {1'($urandom), 4'($urandom_range(0, 10)), 4'($urandom)};
            v[W*i +: W] = s;
        end
        return v;
    endfunction

    // Textbook iterative DIT FFT on integers with the datapath's rounding rules.
    task automatic model_fft();
        longint xr[32], xi[32], wr[16], wi[16];
        longint ar, ai, tr, ti;
        int     len, half, k, a, b;
        for (int n = 0; n < N; n++) begin
            xr[bitrev5(n)] = m_dec(in_re[W*n +: W]);
            xi[bitrev5(n)] = m_dec(in_im[W*n +: W]);
        end
        for (int e = 0; e < 8; e++) begin
            wr[e]   = m_dec(tw_re[W*(4*e+2) +: W]);
            wi[e]   = m_dec(tw_im[W*(4*e+2) +: W]);
            wr[e+8] = wi[e];
            wi[e+8] = -wr[e];
        end
        len = 2;
        while (len <= N) begin
            half = len / 2;
            for (int base = 0; base < N; base += len) begin
                for (int j = 0; j < half; j++) begin
                    k  = j * (N / len);
                    a  = base + j;
                    b  = a + half;
                    tr = clampf(rnd7(xr[b] * wr[k]) - rnd7(xi[b] * wi[k]));
                    ti = clampf(rnd7(xr[b] * wi[k]) + rnd7(xi[b] * wr[k]));
                    ar = xr[a];
                    ai = xi[a];
                    xr[a] = clampf(ar + tr);
                    xi[a] = clampf(ai + ti);
                    xr[b] = clampf(ar - tr);
                    xi[b] = clampf(ai - ti);
                end
            end
            len *= 2;
        end
        for (int k2 = 0; k2 < N; k2++) begin
            exp_re[W*k2 +: W] = m_enc(xr[k2]);
            exp_im[W*k2 +: W] = m_enc(xi[k2]);
        end
    endtask

    task automatic ideal_twiddles();
        real    ang;
        longint fr, fi;
        int     idx;
        for (int m = 0; m < 8; m++) begin
            for (int j = 0; j < 4; j++) begin
                idx = 4*m + 3 - j;
                if (j == 1) begin
                    ang = 2.0 * 3.14159265358979 * real'(j * m) / 32.0;
                    fr  = longint'($rtoi($floor($cos(ang) * 128.0 + 0.5)));
                    fi  = longint'($rtoi($floor(-$sin(ang) * 128.0 + 0.5)));
                    tw_re[W*idx +: W] = m_enc(fr);
                    tw_im[W*idx +: W] = m_enc(fi);
                end else begin
                    tw_re[W*idx +: W] = 9'($urandom);
                    tw_im[W*idx +: W] = 9'($urandom);
                end
            end
        end
    endtask

    // Call at a negedge; returns at the negedge where fft_done is seen.
    // Inputs are scrambled once LOAD has captured them.
    task automatic start_and_wait(output int lat);
        fft_size  = 11'd32;
        fft_start = 1'b1;
        @(negedge clk);
        fft_start = 1'b0;
        lat = 0;
        while (fft_done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                in_re = rand_vec();
                in_im = rand_vec();
                tw_re = rand_vec();
                tw_im = rand_vec();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fft_start = 1'b0;
        fft_size = 11'd32;
        in_re = '0; in_im = '0; tw_re = '0; tw_im = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_re !== '0) begin n_fail++; $display("FAIL reset_out_re: got %h expected 0", out_re); end
        n_checks++;
        if (out_im !== '0) begin n_fail++; $display("FAIL reset_out_im: got %h expected 0", out_im); end
        n_checks++;
        if (fft_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", fft_done); end
        @(negedge clk);
    endtask

    task automatic test_impulse();
        int lat;
        in_re = '0; in_im = '0;
        in_re[8:0] = 9'b010000000;
        ideal_twiddles();
        start_and_wait(lat);
        n_checks++;
        if (lat != 82) begin n_fail++; $display("FAIL impulse_latency: got %0d expected 82", lat); end
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (out_re[W*k +: W] !== 9'b010000000 || out_im[W*k +: W] !== 9'd0) begin
                n_fail++;
                $display("FAIL impulse bin %0d: got %h/%h expected 080/000", k, out_re[W*k +: W], out_im[W*k +: W]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (fft_done !== 1'b0) begin n_fail++; $display("FAIL impulse_pulse_width: got %b expected 0", fft_done); end
    endtask

    task automatic test_spectra();
        int   lat;
        real  v;
        logic [8:0] spot_got, spot_exp;
        for (int pat = 0; pat < 8; pat++) begin
            in_re = '0; in_im = '0;
            ideal_twiddles();
            case (pat)
                0: for (int n = 0; n < N; n++) in_re[W*n +: W] = 9'b010000000;
                1: in_re[W*1 +: W] = 9'b010000000;
                2: for (int n = 0; n < N; n++) in_re[W*n +: W] = 9'b011111111;
                3: for (int n = 0; n < N; n++) begin
                    v = 0.1 + real'(n) * 3.15 / 31.0;
                    in_re[W*n +: W] = m_enc(longint'($rtoi(v * 128.0 + 0.5)));
                end
                7: begin
                    in_re = rand_samples(); in_im = rand_samples();
                    tw_re = rand_vec(); tw_im = rand_vec();
                end
                default: begin in_re = rand_samples(); in_im = rand_samples(); end
            endcase
            model_fft();
            spot_exp = 9'd0;
            case (pat)
                0: spot_exp = 9'b011010000;
                1: spot_exp = 9'b110000000;
                2: spot_exp = 9'b011111111;
                default: spot_exp = 9'd0;
            endcase
            start_and_wait(lat);
            n_checks++;
            if (lat != 82) begin n_fail++; $display("FAIL spectra%0d_latency: got %0d expected 82", pat, lat); end
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (out_re[W*k +: W] !== exp_re[W*k +: W] || out_im[W*k +: W] !== exp_im[W*k +: W]) begin
                    n_fail++;
                    $display("FAIL spectra%0d bin %0d: got %h/%h expected %h/%h", pat, k,
                             out_re[W*k +: W], out_im[W*k +: W], exp_re[W*k +: W], exp_im[W*k +: W]);
                end
            end
            if (pat <= 2) begin
                spot_got = (pat == 1) ? out_re[W*16 +: W] : out_re[8:0];
                n_checks++;
                if (spot_got !== spot_exp) begin
                    n_fail++;
                    $display("FAIL spectra%0d_spot: got %h expected %h", pat, spot_got, spot_exp);
                end
            end
            if (pat == 1) begin
                n_checks++;
                if (out_im[W*8 +: W] !== 9'b110000000 || out_re[W*8 +: W] !== 9'd0) begin
                    n_fail++;
                    $display("FAIL shifted_bin8: got %h/%h expected 000/180", out_re[W*8 +: W], out_im[W*8 +: W]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        in_re = rand_samples(); in_im = rand_samples(); ideal_twiddles();
        model_fft();
        start_and_wait(lat);
        in_re = rand_samples(); in_im = rand_samples(); ideal_twiddles();
        model_fft();
        start_and_wait(lat);
        n_checks++;
        if (lat != 82) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 82", lat); end
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (out_re[W*k +: W] !== exp_re[W*k +: W] || out_im[W*k +: W] !== exp_im[W*k +: W]) begin
                n_fail++;
                $display("FAIL b2b bin %0d: got %h/%h expected %h/%h", k,
                         out_re[W*k +: W], out_im[W*k +: W], exp_re[W*k +: W], exp_im[W*k +: W]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_size_reject();
        int             dones = 0;
        logic [N*W-1:0] held_re;
        held_re   = out_re;
        fft_size  = 11'd16;
        fft_start = 1'b1;
        @(negedge clk);
        fft_start = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (fft_done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL size16_done: got %0d pulses expected 0", dones); end
        n_checks++;
        if (out_re !== held_re) begin n_fail++; $display("FAIL size16_hold: got %h expected %h", out_re, held_re); end
        fft_size = 11'd32;
    endtask

    task automatic test_start_held();
        int dones = 0;
        fft_size  = 11'd32;
        fft_start = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (i == 60) fft_start = 1'b0;
            if (fft_done === 1'b1) dones++;
        end
        fft_start = 1'b0;
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL start_held: got %0d pulses expected 1", dones); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        in_re = rand_samples(); in_im = rand_samples(); ideal_twiddles();
        fft_size  = 11'd32;
        fft_start = 1'b1;
        @(negedge clk);
        fft_start = 1'b0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            rst = (i == 40);
            if (fft_done === 1'b1) dones++;
        end
        rst = 1'b0;
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", dones); end
        n_checks++;
        if (out_re !== '0 || out_im !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h/%h expected 0", out_re, out_im);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_spectra();
        test_back_to_back();
        test_size_reject();
        test_start_held();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
